// File: rtl/axis_cfg.sv
// AXI4-Lite slave keeping a shadow register file and broadcasting each write as a one-cycle cfg strobe.
// Write: AW+W accepted together -> cfg_valid/s_bvalid two cycles later; one write in flight, held by s_bready.
module axis_cfg #(
  parameter int CFG_AWIDTH     = 5,
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [31:0]               s_wdata,
  input  logic [3:0]                s_wstrb,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [31:0]               s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [CFG_AWIDTH-1:0]     cfg_addr,
  output logic [CFG_DWIDTH-1:0]     cfg_data,
  output logic                      cfg_valid
);

  localparam int NREG = 2 ** CFG_AWIDTH;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t                wstate;
  rstate_t                rstate;
  logic                   aw_held;
  logic                   w_held;
  logic [CFG_AWIDTH-1:0]  aw_idx;
  logic [31:0]            w_data;
  logic [3:0]             w_strb;
  logic [CFG_DWIDTH-1:0]  shadow [NREG];
  logic [CFG_DWIDTH-1:0]  merged;
  logic                   aw_fire;
  logic                   w_fire;
  logic                   ar_fire;
  logic                   unused_addr;

  // Byte lanes and address bits above the word index alias onto the same register.
  assign unused_addr = ^{s_awaddr[AXI_ADDR_WIDTH-1:CFG_AWIDTH+2], s_awaddr[1:0],
                         s_araddr[AXI_ADDR_WIDTH-1:CFG_AWIDTH+2], s_araddr[1:0]};

  assign s_awready = (wstate == W_IDLE) && !aw_held;
  assign s_wready  = (wstate == W_IDLE) && !w_held;
  assign s_arready = (rstate == R_IDLE) && (wstate != W_COMMIT);
  assign s_bresp   = 2'b00;
  assign s_rresp   = 2'b00;

  assign aw_fire = s_awvalid && s_awready;
  assign w_fire  = s_wvalid && s_wready;
  assign ar_fire = s_arvalid && s_arready;

  always_comb begin
    merged = shadow[aw_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_strb[b]) merged[8*b +: 8] = w_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate    <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_idx    <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      s_bvalid  <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else begin
      cfg_valid <= 1'b0;
      case (wstate)
        W_IDLE: begin
          if (aw_fire) begin
            aw_held <= 1'b1;
            aw_idx  <= s_awaddr[CFG_AWIDTH+1:2];
          end
          if (w_fire) begin
            w_held <= 1'b1;
            w_data <= s_wdata;
            w_strb <= s_wstrb;
          end
          if ((aw_held || aw_fire) && (w_held || w_fire)) wstate <= W_COMMIT;
        end
        W_COMMIT: begin
          shadow[aw_idx] <= merged;
          cfg_valid      <= 1'b1;
          cfg_addr       <= aw_idx;
          cfg_data       <= merged;
          s_bvalid       <= 1'b1;
          aw_held        <= 1'b0;
          w_held         <= 1'b0;
          wstate         <= W_RESP;
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            wstate   <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // AR is refused during the commit cycle, so a read never sees a half-written word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate   <= R_IDLE;
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_fire) begin
            s_rdata  <= shadow[s_araddr[CFG_AWIDTH+1:2]];
            s_rvalid <= 1'b1;
            rstate   <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            rstate   <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_cfg.sv
// Bench for axis_cfg: vector table, hand-written timing sequences and random ops against a shadow model.
`timescale 1ns/1ps
module tb_axis_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulse_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cfg_valid) pulse_total <= pulse_total + 1;
  end

  axis_cfg dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the B handshake.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [4:0] got_addr, output logic [31:0] got_data,
                          output int lat, output int pulses);
    int t0;
    bit done;
    got_addr = '0; got_data = '0; lat = -1; pulses = 0; t0 = 0; done = 0;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      bit awf, wf, bf;
      awf = s_awvalid && s_awready;
      wf  = s_wvalid && s_wready;
      bf  = s_bvalid && s_bready;
      if (awf || wf) t0 = cyc;
      if (cfg_valid) begin
        pulses++;
        got_addr = cfg_addr;
        got_data = cfg_data;
        if (lat < 0) lat = cyc - t0;
      end
      if (bf) check("bresp", 32'(s_bresp), 32'd0);
      @(negedge clk);
      if (awf) s_awvalid = 1'b0;
      if (wf)  s_wvalid  = 1'b0;
      if (bf)  done = 1;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("write_done", 32'(done), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
    bit done;
    done = 0; data = '0;
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      bit arf, rf;
      arf = s_arvalid && s_arready;
      rf  = s_rvalid && s_rready;
      if (rf) data = s_rdata;
      @(negedge clk);
      if (arf) s_arvalid = 1'b0;
      if (rf)  done = 1;
    end
    s_arvalid = 1'b0;
    check("read_done", 32'(done), 32'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [4:0]  exp_idx;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [4:0]  ga;
    logic [31:0] gd;
    int          lat, pulses, p0, bad;
    bit          ok_a, ok_b;
    logic [31:0] model [32];

    vecs[0] = '{1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h0C, 32'hAABBCCDD, 4'hF, 5'd3,  32'hAABBCCDD};
    vecs[2] = '{1'b1, 32'h0C, 32'h11223344, 4'h5, 5'd3,  32'hAA22CC44};
    vecs[3] = '{1'b0, 32'h0C, 32'h0,        4'h0, 5'd0,  32'hAA22CC44};
    vecs[4] = '{1'b0, 32'h0F, 32'h0,        4'h0, 5'd0,  32'hAA22CC44};
    vecs[5] = '{1'b1, 32'h80, 32'h0000FFFF, 4'h0, 5'd0,  32'h00000000};
    vecs[6] = '{1'b0, 32'h14, 32'h0,        4'h0, 5'd0,  32'hDEADBEEF};
    vecs[7] = '{1'b1, 32'h7C, 32'hCAFEF00D, 4'hC, 5'd31, 32'hCAFE0000};
    vecs[8] = '{1'b0, 32'hFC, 32'h0,        4'h0, 5'd0,  32'hCAFE0000};
    vecs[9] = '{1'b0, 32'h08, 32'h0,        4'h0, 5'd0,  32'h00000000};

    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_readies", 32'({s_awready, s_wready, s_arready}), 32'h7);
    check("rst_valids",  32'({s_bvalid, s_rvalid, cfg_valid}), 32'h0);
    check("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    check("rst_cfg_data", cfg_data, 32'd0);
    check("rst_rdata", s_rdata, 32'd0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, ga, gd, lat, pulses);
        check($sformatf("vec%0d_cfg_addr", i), 32'(ga), 32'(vecs[i].exp_idx));
        check($sformatf("vec%0d_cfg_data", i), gd, vecs[i].exp);
        check($sformatf("vec%0d_pulses", i), 32'(pulses), 32'd1);
        check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        check($sformatf("vec%0d_cfg_valid_low", i), 32'(cfg_valid), 32'd0);
      end else begin
        do_read(vecs[i].addr, gd);
        check($sformatf("vec%0d_rdata", i), gd, vecs[i].exp);
      end
    end

    // W leads AW by three cycles; W stays blocked until the B handshake.
    p0 = pulse_total;
    s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
    check("t2_wready_idle", 32'(s_wready), 32'd1);
    @(negedge clk);
    s_wvalid = 1'b0;
    ok_a = 1;
    repeat (2) begin
      if (s_wready) ok_a = 0;
      @(negedge clk);
    end
    check("t2_wready_low_waiting", 32'(ok_a), 32'd1);
    s_awaddr = 32'h08; s_awvalid = 1'b1;
    check("t2_awready", 32'(s_awready), 32'd1);
    @(negedge clk);
    s_awvalid = 1'b0;
    @(negedge clk);
    check("t2_cfg_valid", 32'(cfg_valid), 32'd1);
    check("t2_cfg_addr", 32'(cfg_addr), 32'd2);
    check("t2_cfg_data", cfg_data, 32'h12345678);
    check("t2_bvalid", 32'(s_bvalid), 32'd1);
    check("t2_wready_resp", 32'(s_wready), 32'd0);
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    check("t2_bvalid_done", 32'(s_bvalid), 32'd0);
    check("t2_wready_back", 32'(s_wready), 32'd1);
    check("t2_pulses", 32'(pulse_total - p0), 32'd1);

    // B withheld for 10 cycles while another AW/W is offered.
    p0 = pulse_total;
    s_awaddr = 32'h10; s_wdata = 32'h0F0F0F0F; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    check("t4_cfg_data", cfg_data, 32'h0F0F0F0F);
    s_awaddr = 32'h18; s_wdata = 32'h99; s_awvalid = 1'b1; s_wvalid = 1'b1;
    ok_a = 1; ok_b = 1;
    repeat (10) begin
      if (!s_bvalid) ok_b = 0;
      if (s_awready || s_wready) ok_a = 0;
      @(negedge clk);
    end
    check("t4_bvalid_held", 32'(ok_b), 32'd1);
    check("t4_readies_low", 32'(ok_a), 32'd1);
    check("t4_pulses", 32'(pulse_total - p0), 32'd1);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    check("t4_bvalid_done", 32'(s_bvalid), 32'd0);

    // AR offered during the commit cycle of a write to the same word.
    s_awaddr = 32'h0C; s_wdata = 32'h55667788; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_rready = 1'b0;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 32'h0C; s_arvalid = 1'b1;
    check("t5_arready_commit", 32'(s_arready), 32'd0);
    @(negedge clk);
    check("t5_arready_resp", 32'(s_arready), 32'd1);
    s_bready = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0; s_bready = 1'b0;
    check("t5_rvalid", 32'(s_rvalid), 32'd1);
    check("t5_rdata", s_rdata, 32'h55667788);
    ok_a = 1;
    repeat (5) begin
      if (!s_rvalid || s_rdata !== 32'h55667788) ok_a = 0;
      @(negedge clk);
    end
    check("t5_rdata_stable", 32'(ok_a), 32'd1);
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
    check("t5_rvalid_done", 32'(s_rvalid), 32'd0);

    // Reset while sitting in the response phase.
    s_awaddr = 32'h04; s_wdata = 32'h77; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_pre_bvalid", 32'(s_bvalid), 32'd1);
    p0 = pulse_total;
    rst = 1'b1;
    #1;
    check("t6_bvalid_async", 32'(s_bvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_readies", 32'({s_awready, s_wready, s_arready}), 32'h7);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      do_read(32'(i * 4), gd);
      if (gd !== 32'd0) bad++;
    end
    check("t6_nonzero_regs", 32'(bad), 32'd0);
    check("t6_no_pulse", 32'(pulse_total - p0), 32'd0);

    // Random traffic against a word-array model, starting from reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d, mask, exp;
      logic [3:0]  st;
      int          idx;
      a   = $urandom;
      d   = $urandom;
      st  = 4'($urandom_range(0, 15));
      idx = int'((a / 4) % 32);
      if ($urandom_range(0, 1) == 1) begin
        mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
        exp  = (model[idx] & ~mask) | (d & mask);
        do_write(a, d, st, ga, gd, lat, pulses);
        check($sformatf("rnd%0d_wr_addr", n), 32'(ga), 32'(idx));
        check($sformatf("rnd%0d_wr_data", n), gd, exp);
        model[idx] = exp;
      end else begin
        do_read(a, gd);
        check($sformatf("rnd%0d_rd_data", n), gd, model[idx]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
